resbuf: RTL and testbench

RESBUF -- requirements
Module: resbuf

---
 rtl/resbuf_pkg.sv | 21 ++
 rtl/resbuf_buf.sv | 27 ++
 rtl/resbuf.sv | 169 ++++++++++++++++
 tb/tb_resbuf.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/resbuf_pkg.sv
// Shared definitions for the result buffer: data/address widths, the
// capture state encoding and the length-decode helper.
package resbuf_pkg;

  localparam int unsigned RESBUF_DW     = 16;
  localparam int unsigned RESBUF_AW     = 9;
  localparam int unsigned RESBUF_BUS_AW = 10;
  localparam int unsigned RESBUF_LW     = RESBUF_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } resbuf_state_e;

  // A programmed length of zero stands for a full buffer of 2**AW words.
  function automatic logic [RESBUF_LW-1:0] eff_len(input logic [RESBUF_BUS_AW-1:0] l);
    return (l == '0) ? RESBUF_LW'(2 ** RESBUF_AW) : RESBUF_LW'(l);
  endfunction

endpackage

// File: rtl/resbuf_buf.sv
// buf_1r1w: simple dual-port RAM, one write port, one registered read port.
// A read of the address written in the same cycle returns the old word.
// Contents are never reset.
module buf_1r1w #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/resbuf.sv
// resbuf: captures a burst of systolic-array result words into a 512x16
// buffer and exposes the buffer on a 1-cycle-latency read bus.
// Optional feature macro RESBUF_ACC_EN: accumulate capture (read-add-write)
// selected per capture by acc_mode.
module resbuf
  import resbuf_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RESBUF_BUS_AW-1:0] res_len,
  input  logic                     res_valid,
  input  logic [RESBUF_DW-1:0]     res_data,
  input  logic                     acc_mode,
  input  logic                     ren,
  input  logic [RESBUF_BUS_AW-1:0] resbus_radr,
  output logic [RESBUF_DW-1:0]     resbus_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic [RESBUF_LW-1:0]     wcnt
);

  resbuf_state_e          state_q, state_d;
  logic [RESBUF_AW-1:0]   wptr_q, wptr_d;
  logic [RESBUF_LW-1:0]   wcnt_q, wcnt_d;
  logic [RESBUF_LW-1:0]   len_q, len_d;
  logic                   ovf_q, ovf_d;

  logic                   ram_we;
  logic [RESBUF_AW-1:0]   ram_waddr;
  logic [RESBUF_DW-1:0]   ram_wdata;
  logic [RESBUF_AW-1:0]   ram_raddr;
  logic [RESBUF_DW-1:0]   ram_rdata;

`ifdef RESBUF_ACC_EN
  logic                   acc_q, acc_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [RESBUF_AW-1:0]   s2_addr_q, s2_addr_d;
  logic [RESBUF_DW-1:0]   s2_data_q, s2_data_d;
  logic                   acc_cap;
  logic                   unused_radr;
  assign unused_radr = resbus_radr[RESBUF_BUS_AW-1];
`else
  logic                   unused_in;
  assign unused_in = ^{acc_mode, resbus_radr[RESBUF_BUS_AW-1]};
`endif

  // Next-state, capture datapath and RAM port steering.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ram_wdata = res_data;
    ram_raddr = ren ? resbus_radr[RESBUF_AW-1:0] : wptr_q;
`ifdef RESBUF_ACC_EN
    acc_d      = acc_q;
    s2_valid_d = 1'b0;
    s2_addr_d  = s2_addr_q;
    s2_data_d  = s2_data_q;
    acc_cap    = (state_q == ST_CAPTURE) && acc_q;
    if (acc_cap) ram_raddr = wptr_q;
`endif

    if (start) begin
      state_d = ST_CAPTURE;
      wptr_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      len_d   = eff_len(res_len);
`ifdef RESBUF_ACC_EN
      acc_d   = acc_mode;
`endif
    end else begin
      if (res_valid) begin
        if ((state_q == ST_CAPTURE) && (wcnt_q != len_q)) begin
          wptr_d = wptr_q + 1'b1;
          wcnt_d = wcnt_q + 1'b1;
`ifdef RESBUF_ACC_EN
          if (acc_q) begin
            s2_valid_d = 1'b1;
            s2_addr_d  = wptr_q;
            s2_data_d  = res_data;
          end else begin
            ram_we = 1'b1;
            if (wcnt_d == len_q) state_d = ST_DONE;
          end
`else
          ram_we = 1'b1;
          if (wcnt_d == len_q) state_d = ST_DONE;
`endif
        end else begin
          ovf_d = 1'b1;
        end
      end
`ifdef RESBUF_ACC_EN
      // Accumulate capture holds CAPTURE for the cycle of the final stage-2
      // write, so done follows the last write rather than the last accept.
      if (acc_cap && (wcnt_q == len_q)) state_d = ST_DONE;
`endif
    end

`ifdef RESBUF_ACC_EN
    // Stage 2: the word read last cycle is now on ram_rdata.
    if (s2_valid_q) begin
      ram_we    = 1'b1;
      ram_waddr = s2_addr_q;
      ram_wdata = ram_rdata + s2_data_q;
    end
`endif
  end

  // Control and status registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RESBUF_ACC_EN
  // Accumulate-mode latch and stage-2 pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
    end
  end
`endif

  buf_1r1w #(
    .DW(RESBUF_DW),
    .AW(RESBUF_AW)
  ) u_buf (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign resbus_rdata = ram_rdata;
  assign busy         = (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);
  assign ovf          = ovf_q;
  assign wcnt         = wcnt_q;

endmodule

// File: tb/tb_resbuf.sv
// Bench for resbuf: directed scenarios plus randomized captures, all checked
// every cycle against a word-level model of the buffer.
module tb_resbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  res_len = '0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        acc_mode = 1'b0;
  logic        ren = 1'b0;
  logic [9:0]  resbus_radr = '0;
  logic [15:0] resbus_rdata;
  logic        busy, done, ovf;
  logic [9:0]  wcnt;

`ifdef RESBUF_ACC_EN
  localparam bit ACC_BUILD = 1'b1;
`else
  localparam bit ACC_BUILD = 1'b0;
`endif

  resbuf dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_len(res_len),
    .res_valid(res_valid), .res_data(res_data), .acc_mode(acc_mode),
    .ren(ren), .resbus_radr(resbus_radr), .resbus_rdata(resbus_rdata),
    .busy(busy), .done(done), .ovf(ovf), .wcnt(wcnt)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Model: buffer contents plus capture status.
  logic [15:0] m_mem [512];
  bit          m_known [512];
  bit          m_cap, m_done, m_ovf, m_acc, m_drain;
  int unsigned m_cnt, m_len, m_ptr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_status();
    m_cap = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_drain = 0;
    m_cnt = 0; m_ptr = 0; m_len = 0;
  endtask

  task automatic check_status();
    check("busy", 16'(busy), 16'(m_cap));
    check("done", 16'(done), 16'(m_done));
    check("ovf",  16'(ovf),  16'(m_ovf));
    check("wcnt", 16'(wcnt), 16'(m_cnt));
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic st, input logic [9:0] len, input logic am,
                      input logic v, input logic [15:0] d,
                      input logic rd, input logic [9:0] ra);
    int unsigned a;
    bit          chk_rd, was_drain;
    logic [15:0] exp_rd;
    start = st; res_len = len; acc_mode = am; res_valid = v; res_data = d;
    ren = rd; resbus_radr = ra;
    a      = ra % 512;
    chk_rd = rd && m_known[a] && !(m_cap && m_acc);
    exp_rd = m_mem[a];
    was_drain = m_drain;
    m_drain   = 0;
    if (st) begin
      m_cap = 1; m_done = 0; m_ovf = 0; m_cnt = 0; m_ptr = 0;
      m_len = (len == 0) ? 512 : len;
      m_acc = ACC_BUILD && am;
    end else begin
      if (v) begin
        if (m_cap && m_cnt < m_len) begin
          if (m_acc) m_mem[m_ptr] = m_mem[m_ptr] + d;
          else begin
            m_mem[m_ptr] = d;
            m_known[m_ptr] = 1;
          end
          m_ptr = (m_ptr + 1) % 512;
          m_cnt++;
          if (m_cnt == m_len) begin
            if (m_acc) m_drain = 1;
            else begin m_cap = 0; m_done = 1; end
          end
        end else begin
          m_ovf = 1;
        end
      end
      if (was_drain) begin m_cap = 0; m_done = 1; end
    end
    @(posedge clk); #1;
    check_status();
    if (chk_rd) check("rdata", resbus_rdata, exp_rd);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 16'h0, 0, 10'h0);
  endtask

  task automatic word(input logic [15:0] d);
    step(0, 0, 0, 1, d, 0, 10'h0);
  endtask

  task automatic rd_addr(input logic [9:0] a);
    step(0, 0, 0, 0, 16'h0, 1, a);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic mid_reset();
    start = 0; res_valid = 0; ren = 0;
    rst_n = 1'b0;
    #2;
    model_clear_status();
    check_status();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len;
    for (int i = 0; i < 512; i++) begin m_known[i] = 0; m_mem[i] = '0; end
    model_clear_status();

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status();

    // Full-length capture (length 0 = 512) with gaps and bus reads.
    step(1, 10'd0, 0, 0, 16'h0, 0, 10'h0);
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(7) == 0) step(0, 0, 0, 0, 16'h0, 1'($urandom), 10'($urandom));
      step(0, 0, 0, 1, 16'($urandom), 1'($urandom), 10'($urandom));
    end
    idle();

    // Short capture after the full one overwrites 0..2 only.
    step(1, 10'd3, 0, 0, 16'h0, 0, 10'h0);
    for (int i = 0; i < 3; i++) word(16'h0A00 + 16'(i));
    for (int i = 0; i < 5; i++) rd_addr(10'(i));

    // Length-4 capture, readback of 0..3, then an overflowing word.
    step(1, 10'd4, 0, 0, 16'h0, 0, 10'h0);
    for (int i = 0; i < 4; i++) word(16'h0011 + 16'(i));
    for (int i = 0; i < 4; i++) rd_addr(10'(i));
    word(16'h0015);
    rd_addr(10'd4);
    rd_addr(10'h204);

    // start wins over a same-cycle result word.
    step(1, 10'd5, 0, 1, 16'hBEEF, 0, 10'h0);
    idle();
    rd_addr(10'd0);

    // Reset in the middle of a capture leaves the RAM intact.
    step(1, 10'd8, 0, 0, 16'h0, 0, 10'h0);
    word(16'h0021);
    word(16'h0022);
    mid_reset();
    rd_addr(10'd0);
    rd_addr(10'd1);
    word(16'h0099);
    rd_addr(10'd2);

    // Randomized captures, including start+valid collisions and words after done.
    for (int c = 0; c < 10; c++) begin
      len = $urandom_range(24, 1);
      step(1, 10'(len), ACC_BUILD ? 1'b0 : 1'($urandom), 1'($urandom),
           16'($urandom), 0, 10'h0);
      for (int k = 0; k < int'(2 * len + 6); k++)
        step(0, 0, 0, 1'($urandom_range(3) != 0), 16'($urandom),
             1'($urandom), 10'($urandom));
    end

`ifdef RESBUF_ACC_EN
    // Accumulate: zero 0..1, then two accumulating captures of 0x8000,0x0001.
    step(1, 10'd2, 0, 0, 16'h0, 0, 10'h0);
    word(16'h0000);
    word(16'h0000);
    for (int r = 0; r < 2; r++) begin
      step(1, 10'd2, 1, 0, 16'h0, 0, 10'h0);
      word(16'h8000);
      word(16'h0001);
      idle();
      idle();
    end
    rd_addr(10'd0);
    check("acc_ram0", resbus_rdata, 16'h0000);
    rd_addr(10'd1);
    check("acc_ram1", resbus_rdata, 16'h0002);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
